// File: rtl/change_dispenser_pkg.sv
// Shared types for the change dispenser: FSM state encoding and coin selection.
// Step values are in units of 5, the resolution of the change amount.
package change_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEL      = 3'd1,
        ST_PULSE    = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_DONE     = 3'd4,
        ST_ERR      = 3'd5
    } state_t;

    typedef enum logic {
        COIN_5  = 1'b0,
        COIN_10 = 1'b1
    } coin_t;

    localparam logic [1:0] STEP_10 = 2'd2;
    localparam logic [1:0] STEP_5  = 2'd1;

    function automatic logic [1:0] coin_step(input coin_t c);
        return (c == COIN_10) ? STEP_10 : STEP_5;
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Bundle between the vending controller / hopper hardware (master) and the dispenser (slave).
interface change_dispenser_if #(
    parameter int AMT_W = 4
);
    // change_req is a 1-cycle strobe with change_amt valid alongside; it is only
    // accepted while busy is low, otherwise dropped. done is a 1-cycle pulse,
    // err is a level held with unpaid until err_clr. coin_sensed is a 1-cycle pulse.
    logic             change_req;
    logic [AMT_W-1:0] change_amt;
    logic             hop10_empty;
    logic             hop5_empty;
    logic             coin_sensed;
    logic             err_clr;
    logic             hop10_drv;
    logic             hop5_drv;
    logic             busy;
    logic             done;
    logic             err;
    logic [AMT_W-1:0] unpaid;

    modport master (
        output change_req, change_amt, hop10_empty, hop5_empty, coin_sensed, err_clr,
        input  hop10_drv, hop5_drv, busy, done, err, unpaid
    );

    modport slave (
        input  change_req, change_amt, hop10_empty, hop5_empty, coin_sensed, err_clr,
        output hop10_drv, hop5_drv, busy, done, err, unpaid
    );

endinterface

// File: rtl/change_dispenser_timer.sv
// Loadable up-counter with clear and terminal-count compare; one instance serves
// both the drive pulse width and the sensor timeout.
module change_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic [W-1:0] i_tc_val,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == i_tc_val);

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays a requested amount with 10- and 5-unit hoppers,
// one coin at a time, waiting for the exit sensor between coins.
module change_dispenser
    import change_pkg::*;
#(
    parameter int AMT_W       = 4,
    parameter int PULSE_CYC   = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    change_dispenser_if.slave  if_bus,
    output state_t             o_dbg_state
);

    localparam int TMAX = (PULSE_CYC > TIMEOUT_CYC) ? PULSE_CYC : TIMEOUT_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    state_t           r_state, w_state_nxt;
    coin_t            r_coin, w_coin_nxt;
    logic [AMT_W-1:0] r_remain, w_remain_nxt;
    logic             r_sensed, w_sensed_nxt;
    logic             r_hop10_drv, r_hop5_drv, r_busy, r_done, r_err;
    logic [AMT_W-1:0] r_unpaid;
    logic             w_tmr_clr, w_tmr_en, w_tmr_tc;
    logic [TW-1:0]    w_tc_val;
    logic [AMT_W-1:0] w_step;

    assign w_step   = AMT_W'(coin_step(r_coin));
    assign w_tc_val = (r_state == ST_PULSE) ? TW'(PULSE_CYC - 1) : TW'(TIMEOUT_CYC - 1);

    change_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_tmr_clr),
        .i_en       (w_tmr_en),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_tc_val   (w_tc_val),
        .o_tc       (w_tmr_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_remain_nxt = r_remain;
        w_coin_nxt   = r_coin;
        w_sensed_nxt = r_sensed;
        w_tmr_clr    = 1'b0;
        w_tmr_en     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (if_bus.change_req) begin
                    if (if_bus.change_amt != '0) begin
                        w_remain_nxt = if_bus.change_amt;
                        w_state_nxt  = ST_SEL;
                    end else begin
                        w_state_nxt  = ST_DONE;
                    end
                end
            end
            ST_SEL: begin
                w_sensed_nxt = 1'b0;
                w_tmr_clr    = 1'b1;
                if (r_remain == '0) begin
                    w_state_nxt = ST_DONE;
                end else if (r_remain >= AMT_W'(STEP_10) && !if_bus.hop10_empty) begin
                    w_coin_nxt  = COIN_10;
                    w_state_nxt = ST_PULSE;
                end else if (!if_bus.hop5_empty) begin
                    w_coin_nxt  = COIN_5;
                    w_state_nxt = ST_PULSE;
                end else begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_PULSE: begin
                w_tmr_en = 1'b1;
                // An early sensor echo is credited once; the pulse still runs to full width.
                if (if_bus.coin_sensed && !r_sensed) begin
                    w_remain_nxt = r_remain - w_step;
                    w_sensed_nxt = 1'b1;
                end
                if (w_tmr_tc) begin
                    w_tmr_clr   = 1'b1;
                    w_state_nxt = (r_sensed || if_bus.coin_sensed) ? ST_SEL : ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                w_tmr_en = 1'b1;
                if (if_bus.coin_sensed) begin
                    w_remain_nxt = r_remain - w_step;
                    w_state_nxt  = ST_SEL;
                end else if (w_tmr_tc) begin
                    w_state_nxt  = ST_ERR;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                if (if_bus.err_clr) begin
                    w_remain_nxt = '0;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they track the state exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remain    <= '0;
            r_coin      <= COIN_5;
            r_sensed    <= 1'b0;
            r_hop10_drv <= 1'b0;
            r_hop5_drv  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_unpaid    <= '0;
        end else begin
            r_remain    <= w_remain_nxt;
            r_coin      <= w_coin_nxt;
            r_sensed    <= w_sensed_nxt;
            r_hop10_drv <= (w_state_nxt == ST_PULSE) && (w_coin_nxt == COIN_10);
            r_hop5_drv  <= (w_state_nxt == ST_PULSE) && (w_coin_nxt == COIN_5);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= (w_state_nxt == ST_DONE);
            r_err       <= (w_state_nxt == ST_ERR);
            r_unpaid    <= (w_state_nxt == ST_ERR) ? w_remain_nxt : '0;
        end
    end

    assign if_bus.hop10_drv = r_hop10_drv;
    assign if_bus.hop5_drv  = r_hop5_drv;
    assign if_bus.busy      = r_busy;
    assign if_bus.done      = r_done;
    assign if_bus.err       = r_err;
    assign if_bus.unpaid    = r_unpaid;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: acts as controller plus hopper/sensor hardware and
// compares each payout with a coin-count model of the payout rules.
module tb_change_dispenser;
  import change_pkg::*;

  localparam int AMT_W       = 4;
  localparam int PULSE_CYC   = 4;
  localparam int TIMEOUT_CYC = 64;
  localparam int BUDGET      = 1500;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;
  int     n_checks = 0;
  int     n_fail = 0;

  change_dispenser_if #(.AMT_W(AMT_W)) bus ();

  change_dispenser #(
    .AMT_W       (AMT_W),
    .PULSE_CYC   (PULSE_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_bus      (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: prefer tens unless the 10 hopper is empty, fives cover the rest.
  // silent_after = number of coins the sensor acknowledges (-1 = all).
  function automatic void model(input int amt, input bit h10e, input bit h5e, input int silent_after,
                                output int e10, output int e5, output bit e_err,
                                output int e_unpaid, output bit e_tmo);
    int tens, fives, paid_tens, paid_fives;
    tens  = h10e ? 0 : amt / 2;
    fives = amt - 2 * tens;
    e_err = 1'b0; e_tmo = 1'b0; e_unpaid = 0;
    if (h5e && fives > 0) begin
      e_err = 1'b1; e_unpaid = fives; fives = 0;
    end
    e10 = tens; e5 = fives;
    if (silent_after >= 0 && silent_after < tens + fives) begin
      paid_tens  = (silent_after < tens) ? silent_after : tens;
      paid_fives = silent_after - paid_tens;
      e10 = (silent_after + 1 < tens) ? silent_after + 1 : tens;
      e5  = silent_after + 1 - e10;
      e_err = 1'b1; e_tmo = 1'b1;
      e_unpaid = amt - 2 * paid_tens - paid_fives;
    end
  endfunction

  task automatic run_payout(input int amt, input bit h10e, input bit h5e, input int silent_after);
    int e10, e5, e_unpaid;
    bit e_err, e_tmo;
    int cyc, n10, n5, coin_no, width, bad_width, overlap, sense_cnt, late_delay;
    int first_rise, first_coin, last_fall, err_cyc, done_cyc, done_seen, got_unpaid, inject_at;
    bit p10, p5, d10, d5, finished, err_seen, late;
    model(amt, h10e, h5e, silent_after, e10, e5, e_err, e_unpaid, e_tmo);
    n10 = 0; n5 = 0; coin_no = 0; width = 0; bad_width = 0; overlap = 0; sense_cnt = 0;
    late_delay = 0; first_rise = -1; first_coin = 0; last_fall = -1; err_cyc = -1;
    done_cyc = -1; done_seen = 0; got_unpaid = 0; p10 = 0; p5 = 0; finished = 0;
    err_seen = 0; late = 0;
    inject_at = $urandom_range(3, 12);
    bus.hop10_empty = h10e;
    bus.hop5_empty  = h5e;
    @(negedge clk);
    bus.change_req = 1'b1;
    bus.change_amt = AMT_W'(amt);
    cyc = 0;
    while (!finished && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      bus.change_req  = 1'b0;
      bus.coin_sensed = 1'b0;
      if (cyc == inject_at && bus.busy) begin
        bus.change_req = 1'b1;
        bus.change_amt = AMT_W'($urandom_range(1, 15));
      end
      d10 = bus.hop10_drv;
      d5  = bus.hop5_drv;
      if (d10 && d5) overlap++;
      if (sense_cnt > 0) begin
        sense_cnt--;
        if (sense_cnt == 0) bus.coin_sensed = 1'b1;
      end
      if ((d10 && !p10) || (d5 && !p5)) begin
        if (first_rise < 0) begin
          first_rise = cyc;
          first_coin = d10 ? 10 : 5;
        end
        width = 0;
        late  = 1'b0;
        if (silent_after < 0 || coin_no < silent_after) begin
          if ($urandom_range(0, 2) == 0) sense_cnt = $urandom_range(1, 2);
          else begin
            late = 1'b1;
            late_delay = $urandom_range(1, 6);
          end
        end
        coin_no++;
      end
      if (d10 || d5) width++;
      if ((p10 && !d10) || (p5 && !d5)) begin
        if (width != PULSE_CYC) bad_width++;
        if (p10) n10++; else n5++;
        last_fall = cyc;
        if (late) begin
          sense_cnt = late_delay;
          late = 1'b0;
        end
      end
      p10 = d10;
      p5  = d5;
      if (bus.done) begin
        done_seen++;
        done_cyc = cyc;
        finished = 1'b1;
      end
      if (bus.err) begin
        err_seen   = 1'b1;
        err_cyc    = cyc;
        got_unpaid = int'(bus.unpaid);
        finished   = 1'b1;
      end
    end
    check("finished", int'(finished), 1);
    check("n10", n10, e10);
    check("n5", n5, e5);
    check("err", int'(err_seen), int'(e_err));
    check("done", done_seen, e_err ? 0 : 1);
    check("overlap", overlap, 0);
    check("width", bad_width, 0);
    if (e_err) check("unpaid", got_unpaid, e_unpaid);
    if (e10 + e5 > 0) begin
      check("drive_lat", first_rise, 2);
      check("first_coin", first_coin, (e10 > 0) ? 10 : 5);
    end
    if (e_tmo) check("tmo_cyc", err_cyc - last_fall, TIMEOUT_CYC);
    if (e_err && e10 + e5 == 0) check("err_lat", err_cyc, 2);
    if (!e_err && e10 + e5 == 0) check("done_lat", int'(done_cyc >= 1 && done_cyc <= 2), 1);
    @(negedge clk);
    bus.change_req  = 1'b0;
    bus.coin_sensed = 1'b0;
    if (err_seen) begin
      check("err_hold", int'(bus.err), 1);
      check("unpaid_hold", int'(bus.unpaid), e_unpaid);
      bus.err_clr = 1'b1;
      @(negedge clk);
      bus.err_clr = 1'b0;
      check("clr_err", int'(bus.err), 0);
      check("clr_unpaid", int'(bus.unpaid), 0);
      check("clr_busy", int'(bus.busy), 0);
    end else begin
      check("done_once", int'(bus.done), 0);
      check("idle_busy", int'(bus.busy), 0);
    end
  endtask

  task automatic reset_mid_pulse();
    int waited;
    bus.hop10_empty = 1'b0;
    bus.hop5_empty  = 1'b0;
    @(negedge clk);
    bus.change_req = 1'b1;
    bus.change_amt = AMT_W'(3);
    @(negedge clk);
    bus.change_req = 1'b0;
    waited = 0;
    while (!bus.hop10_drv && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("rst_drv_seen", int'(bus.hop10_drv), 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_drv", int'(bus.hop10_drv), 0);
    check("rst_async_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_busy", int'(bus.busy), 0);
  endtask

  initial begin
    bus.change_req  = 1'b0;
    bus.change_amt  = '0;
    bus.hop10_empty = 1'b0;
    bus.hop5_empty  = 1'b0;
    bus.coin_sensed = 1'b0;
    bus.err_clr     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hop10", int'(bus.hop10_drv), 0);
    check("rst_hop5", int'(bus.hop5_drv), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_unpaid", int'(bus.unpaid), 0);
    check("rst_state", int'(dbg_state), int'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    run_payout(3, 1'b0, 1'b0, -1);
    run_payout(4, 1'b1, 1'b0, -1);
    run_payout(2, 1'b1, 1'b1, -1);
    run_payout(5, 1'b0, 1'b0, 2);
    run_payout(0, 1'b0, 1'b0, -1);
    run_payout(15, 1'b0, 1'b0, -1);
    run_payout(3, 1'b0, 1'b1, -1);
    reset_mid_pulse();
    run_payout(3, 1'b0, 1'b0, -1);

    for (int i = 0; i < 30; i++) begin
      run_payout($urandom_range(0, 15), $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
